// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: memory-completion FSM
// states and the per-stage enable/flush pair.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        I_DONE = 2'd1,
        D_DONE = 2'd2
    } mem_fsm_t;

    typedef struct packed {
        logic en;
        logic flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_ADVANCE = '{en: 1'b1, flush: 1'b0};
    localparam pipe_ctrl_t CTRL_HOLD    = '{en: 1'b0, flush: 1'b0};
    localparam pipe_ctrl_t CTRL_SQUASH  = '{en: 1'b1, flush: 1'b1};

endpackage

// File: rtl/mem_stall_fsm.sv
// Tracks split I/D memory completions so a port that already finished is not
// re-issued while the other is still pending; exports the freeze condition.
module mem_stall_fsm
    import hazard_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_imem_req,
    input  logic i_imem_resp,
    input  logic i_dmem_req,
    input  logic i_dmem_resp,
    output logic o_imem_hold,
    output logic o_dmem_hold,
    output logic o_freeze
);

    mem_fsm_t r_state;
    mem_fsm_t w_next;
    logic     w_i_pend;
    logic     w_d_pend;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: w_next is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            RUN: begin
                // Both responses together leave nothing outstanding, so stay in RUN.
                if (i_imem_resp && i_dmem_req && !i_dmem_resp) begin
                    w_next = I_DONE;
                end else if (i_dmem_resp && i_imem_req && !i_imem_resp) begin
                    w_next = D_DONE;
                end
            end
            I_DONE: begin
                if (i_dmem_resp) begin
                    w_next = RUN;
                end
            end
            D_DONE: begin
                if (i_imem_resp) begin
                    w_next = RUN;
                end
            end
            default: w_next = RUN;
        endcase
    end

    assign w_i_pend    = i_imem_req & ~i_imem_resp & (r_state != I_DONE);
    assign w_d_pend    = i_dmem_req & ~i_dmem_resp & (r_state != D_DONE);
    assign o_freeze    = w_i_pend | w_d_pend;
    assign o_imem_hold = (r_state == I_DONE);
    assign o_dmem_hold = (r_state == D_DONE);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: combines memory freeze, EX redirects and
// load-use detection into per-stage enable/flush controls, plus perf counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_redirect,
    input  logic             imem_req,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic             perf_clear,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_en,
    output logic             memwb_flush,
    output logic             imem_hold,
    output logic             dmem_hold,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] loaduse_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic       w_freeze;
    logic       w_loaduse;
    logic       w_pc_en;
    pipe_ctrl_t w_ifid;
    pipe_ctrl_t w_idex;
    pipe_ctrl_t w_exmem;
    pipe_ctrl_t w_memwb;
    logic       w_stall_inc;
    logic       w_flush_inc;
    logic       w_lu_inc;

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_loaduse_cnt;

    mem_stall_fsm u_mem_fsm (
        .clk         (clk),
        .rst         (rst),
        .i_imem_req  (imem_req),
        .i_imem_resp (imem_resp),
        .i_dmem_req  (dmem_req),
        .i_dmem_resp (dmem_resp),
        .o_imem_hold (imem_hold),
        .o_dmem_hold (dmem_hold),
        .o_freeze    (w_freeze)
    );

    // x0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign w_loaduse = ex_mem_read & (ex_rd != '0) &
                       ((id_use_rs1 & (id_rs1 == ex_rd)) |
                        (id_use_rs2 & (id_rs2 == ex_rd)));

    // Priority: freeze > redirect > load-use bubble > normal advance.
    always_comb begin
        w_pc_en = 1'b1;
        w_ifid  = CTRL_ADVANCE;
        w_idex  = CTRL_ADVANCE;
        w_exmem = CTRL_ADVANCE;
        w_memwb = CTRL_ADVANCE;
        if (w_freeze) begin
            w_pc_en = 1'b0;
            w_ifid  = CTRL_HOLD;
            w_idex  = CTRL_HOLD;
            w_exmem = CTRL_HOLD;
            w_memwb = CTRL_HOLD;
        end else if (ex_redirect) begin
            w_ifid = CTRL_SQUASH;
            w_idex = CTRL_SQUASH;
        end else if (w_loaduse) begin
            w_pc_en = 1'b0;
            w_ifid  = CTRL_HOLD;
            w_idex  = CTRL_SQUASH;
        end
    end

    assign pc_en       = w_pc_en;
    assign ifid_en     = w_ifid.en;
    assign ifid_flush  = w_ifid.flush;
    assign idex_en     = w_idex.en;
    assign idex_flush  = w_idex.flush;
    assign exmem_en    = w_exmem.en;
    assign exmem_flush = 1'b0;
    assign memwb_en    = w_memwb.en;
    assign memwb_flush = 1'b0;

    assign w_stall_inc = w_freeze | (w_loaduse & ~ex_redirect);
    assign w_flush_inc = ex_redirect & ~w_freeze;
    assign w_lu_inc    = w_loaduse & ~ex_redirect & ~w_freeze;

    // Counters saturate at all-ones; clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
            r_loaduse_cnt <= '0;
        end else if (perf_clear) begin
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
            r_loaduse_cnt <= '0;
        end else begin
            if (w_stall_inc && r_stall_cnt != CNT_MAX) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (w_flush_inc && r_flush_cnt != CNT_MAX) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
            if (w_lu_inc && r_loaduse_cnt != CNT_MAX) begin
                r_loaduse_cnt <= r_loaduse_cnt + CNT_ONE;
            end
        end
    end

    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;
    assign loaduse_cnt = r_loaduse_cnt;

endmodule
